post_adder_acc: RTL and testbench
=================================

Name: post_adder_acc

Overview:
Post-adder/accumulator stage of the DSP48A1 slice. It consumes the multiplier product M and the registered or bypassed C, D:A:B and PCIN operands produced by the upstream register/mux stages. It selects X and Z operands via OPMODE, then adds or subtracts them with carry-in. The result goes to the P register, the PCOUT cascade and CARRYOUT. Accumulation uses P feedback.

Parameters:
PREG, 1, 1 = P and PCOUT registered; 0 = combinational (illegal with any P-feedback OPMODE)
OPMODEREG, 1, 1 = OPMODE captured in a register before use; 0 = used directly
CARRYINREG, 1, 1 = selected carry-in registered; 0 = combinational
CARRYOUTREG, 1, 1 = CARRYOUT/CARRYOUTF registered; 0 = combinational
CARRYINSEL, "OPMODE5", carry-in source: "OPMODE5" = OPMODE[5], "CARRYIN" = CARRYIN port; any other value sets carry-in to 0

Ports:
CLK  in  1  single clock, rising edge
RST  in  1  synchronous, active-high; clears every internal register in this block
CEP  in  1  clock enable for P register
CEOPMODE  in  1  clock enable for OPMODE register
CECARRYIN  in  1  clock enable for carry-in and carry-out registers
OPMODE  in  8  [1:0] X select, [3:2] Z select, [5] carry-in (OPMODE5 mode), [7] subtract; [4] and [6] are ignored
M  in  36  multiplier product
C  in  48  C operand
DAB  in  48  concatenation {D[11:0],A[17:0],B[17:0]}
PCIN  in  48  P cascade input
CARRYIN  in  1  external carry-in
P  out  48  result
PCOUT  out  48  copy of P for cascade
CARRYOUT  out  1  bit 48 of the 49-bit result
CARRYOUTF  out  1  fabric copy of CARRYOUT

Behaviour:
- Reset: after a cycle with RST = 1, P, PCOUT, CARRYOUT, CARRYOUTF, the OPMODE register and the carry-in register are all 0. RST has priority over all CEs.
- X mux, from OPMODE[1:0]:
  - 0 -> 48'b0
  - 1 -> {12'b0, M} (zero-extended)
  - 2 -> P (registered value)
  - 3 -> DAB
- Z mux, from OPMODE[3:2]:
  - 0 -> 0
  - 1 -> PCIN
  - 2 -> P
  - 3 -> C
- Arithmetic, 49 bits unsigned:
  - OPMODE[7] = 0: R = {0,Z} + {0,X} + CIN
  - OPMODE[7] = 1: R = {0,Z} - ({0,X} + CIN), modulo 2^49
  - P gets R[47:0]; CARRYOUT gets R[48] (borrow on subtract).
- Latency, operands to P: PREG cycles (1 by default).
  - OPMODE to effect: OPMODEREG + PREG cycles.
  - CARRYIN to effect: CARRYINREG + PREG cycles.
  - CARRYOUT aligns with P only when CARRYOUTREG = PREG.
- Clock enables: CEP = 0 holds P/PCOUT. CECARRYIN = 0 holds both carry registers. CEOPMODE = 0 holds the OPMODE register.
- Accumulate: OPMODE = 0x09 (X = M, Z = P) adds M to P every enabled cycle. Wrap-around at 2^48 sets CARRYOUT for that cycle only.
- Simultaneous events:
  - RST with CEP = 1: reset wins.
  - OPMODE change under OPMODEREG = 1: the old mode applies for one more cycle.
- Reset mid-accumulation: P = 0 on the next edge. Accumulation resumes from 0 once RST is low.
- PCOUT always equals P.

Optional Feature:
- Macro POST_ADDER_PATDET_EN.
- When defined: extra output PATTERNDETECT (1 bit). It is registered with P (same CEP/RST) and set when R[47:0] == C.
- When undefined: the port and comparator are absent.

Decomposition:
- Shared package dsp_pkg: OPMODE bit-index constants, X/Z select encodings, width constants (P_W = 48, M_W = 36).
- One natural sub-module: the existing generic register/bypass cell, instantiated for the OPMODE, carry-in, P and carry-out stages (width 8/1/48/1).
- The adder and muxes stay in this module.

Test Plan:
- Reset/hold: RST = 1 for 2 cycles with arbitrary inputs -> P = 0, CARRYOUT = 0. Then CEP = 0 with DAB = 5, OPMODE = 0x03 -> P stays 0.
- Accumulate: OPMODE = 0x09, M = 3 each cycle for 4 enabled cycles -> P = 3, 6, 9, 12 (with OPMODEREG = 1, first update one cycle late).
- Subtract with carry: OPMODE = 0xAF (Z = C, X = DAB, sub, CIN = OPMODE5 = 1), C = 100, DAB = 30 -> P = 69, CARRYOUT = 0. Then C = 10, DAB = 30 -> P = 2^48 - 21, CARRYOUT = 1.
- Overflow: OPMODE = 0x0B, P = 2^48 - 1, DAB = 2 -> P = 1, CARRYOUT = 1.
- Cascade: OPMODE = 0x07, PCIN = 0x1234, DAB = 1 -> P = PCOUT = 0x1235. Repeat with CARRYINSEL = "CARRYIN", CARRYIN = 1 -> P = 0x1236.
- Reset mid-accumulation at P = 9 -> P = 0 next edge, then 3 after release (POST_ADDER_PATDET_EN: C = 3 -> PATTERNDETECT = 1 that cycle).

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared constants for the DSP48A1 post-adder/accumulator slice:
// datapath widths, OPMODE bit positions and X/Z multiplexer encodings.
package dsp_pkg;

  localparam int P_W      = 48;       // P / C / DAB / PCIN width
  localparam int M_W      = 36;       // multiplier product width
  localparam int R_W      = P_W + 1;  // adder result including carry/borrow
  localparam int OPMODE_W = 8;

  // OPMODE bit positions
  localparam int OP_X_LSB   = 0;      // [1:0] X select
  localparam int OP_Z_LSB   = 2;      // [3:2] Z select
  localparam int OP_CIN_BIT = 5;      // carry-in when sourced from OPMODE
  localparam int OP_SUB_BIT = 7;      // 1 = Z - (X + CIN)

  typedef enum logic [1:0] {
    X_ZERO = 2'd0,
    X_M    = 2'd1,
    X_P    = 2'd2,
    X_DAB  = 2'd3
  } x_sel_e;

  typedef enum logic [1:0] {
    Z_ZERO = 2'd0,
    Z_PCIN = 2'd1,
    Z_P    = 2'd2,
    Z_C    = 2'd3
  } z_sel_e;

endpackage

// File: rtl/post_adder_acc_reg.sv
// Generic pipeline register / bypass cell. REG = 1 gives a clock-enabled
// register with synchronous active-high reset; REG = 0 passes d straight
// through (the register is then left without loads and trimmed away).
module post_adder_acc_reg #(
  parameter int W   = 1,
  parameter int REG = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;

  // Capture d on enabled edges; reset overrides the enable.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so every register samples pre-edge values.
    if (rst)     q_r <= '0;
    else if (ce) q_r <= d;
  end

  assign q = (REG != 0) ? q_r : d;

endmodule

// File: rtl/post_adder_acc.sv
// DSP48A1 post-adder/accumulator. Selects X and Z via OPMODE, computes
// Z +/- (X + CIN) over 49 bits and drives P, PCOUT and CARRYOUT(F).
// Optional build macro: POST_ADDER_PATDET_EN adds the PATTERNDETECT output,
// registered alongside P and set when the 48-bit result equals C.
module post_adder_acc
  import dsp_pkg::*;
#(
  parameter int    PREG        = 1,
  parameter int    OPMODEREG   = 1,
  parameter int    CARRYINREG  = 1,
  parameter int    CARRYOUTREG = 1,
  parameter string CARRYINSEL  = "OPMODE5"
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CEP,
  input  logic        CEOPMODE,
  input  logic        CECARRYIN,
  input  logic [7:0]  OPMODE,
  input  logic [35:0] M,
  input  logic [47:0] C,
  input  logic [47:0] DAB,
  input  logic [47:0] PCIN,
  input  logic        CARRYIN,
  output logic [47:0] P,
  output logic [47:0] PCOUT,
  output logic        CARRYOUT,
  output logic        CARRYOUTF
`ifdef POST_ADDER_PATDET_EN
  , output logic      PATTERNDETECT
`endif
);

  logic [OPMODE_W-1:0] opmode_q;
  logic                cin_d;
  logic                cin_q;
  x_sel_e              x_sel;
  z_sel_e              z_sel;
  logic [P_W-1:0]      x_op;
  logic [P_W-1:0]      z_op;
  logic [R_W-1:0]      r;
  logic                unused_opmode_bits;

  // OPMODE[4] and OPMODE[6] have no function in this stage.
  assign unused_opmode_bits = ^{opmode_q[4], opmode_q[6]};

  post_adder_acc_reg #(.W(OPMODE_W), .REG(OPMODEREG)) u_opmode_reg (
    .clk(CLK), .rst(RST), .ce(CEOPMODE), .d(OPMODE), .q(opmode_q)
  );

  // Carry-in source selection; the OPMODE5 source follows the OPMODE stage.
  always_comb begin
    // NOTE: default first so no path through this block can infer a latch.
    cin_d = 1'b0;
    if (CARRYINSEL == "OPMODE5")      cin_d = opmode_q[OP_CIN_BIT];
    else if (CARRYINSEL == "CARRYIN") cin_d = CARRYIN;
  end

  post_adder_acc_reg #(.W(1), .REG(CARRYINREG)) u_cin_reg (
    .clk(CLK), .rst(RST), .ce(CECARRYIN), .d(cin_d), .q(cin_q)
  );

  assign x_sel = x_sel_e'(opmode_q[OP_X_LSB +: 2]);
  assign z_sel = z_sel_e'(opmode_q[OP_Z_LSB +: 2]);

  // X/Z operand muxes and the 49-bit add/subtract; P feedback is the P output.
  always_comb begin
    x_op = '0;
    z_op = '0;
    case (x_sel)
      X_M:     x_op = {{(P_W - M_W){1'b0}}, M};
      X_P:     x_op = P;
      X_DAB:   x_op = DAB;
      default: x_op = '0;
    endcase
    case (z_sel)
      Z_PCIN:  z_op = PCIN;
      Z_P:     z_op = P;
      Z_C:     z_op = C;
      default: z_op = '0;
    endcase
    if (opmode_q[OP_SUB_BIT])
      r = {1'b0, z_op} - ({1'b0, x_op} + {{P_W{1'b0}}, cin_q});
    else
      r = {1'b0, z_op} + {1'b0, x_op} + {{P_W{1'b0}}, cin_q};
  end

  post_adder_acc_reg #(.W(P_W), .REG(PREG)) u_p_reg (
    .clk(CLK), .rst(RST), .ce(CEP), .d(r[P_W-1:0]), .q(P)
  );

  assign PCOUT = P;

  post_adder_acc_reg #(.W(1), .REG(CARRYOUTREG)) u_cout_reg (
    .clk(CLK), .rst(RST), .ce(CECARRYIN), .d(r[P_W]), .q(CARRYOUT)
  );

  assign CARRYOUTF = CARRYOUT;

`ifdef POST_ADDER_PATDET_EN
  logic patdet_d;
  assign patdet_d = (r[P_W-1:0] == C);

  post_adder_acc_reg #(.W(1), .REG(PREG)) u_patdet_reg (
    .clk(CLK), .rst(RST), .ce(CEP), .d(patdet_d), .q(PATTERNDETECT)
  );
`endif

endmodule

// File: tb/tb_post_adder_acc.sv
// Scoreboard bench for post_adder_acc. Stimulus pushes hand-computed
// expectations tagged with the clock edge at which they must hold; a
// monitor on the falling edge pops and compares them. A second instance
// uses the CARRYIN port as carry-in source.
module tb_post_adder_acc;
  import dsp_pkg::*;

  logic        clk = 1'b0;
  logic        rst, cep, ceopmode, cecarryin, carryin;
  logic [7:0]  opmode;
  logic [35:0] m;
  logic [47:0] c, dab, pcin;

  logic [47:0] p0, pcout0, p1, pcout1;
  logic        co0, cof0, co1, cof1;
`ifdef POST_ADDER_PATDET_EN
  logic        pd0, pd1;
`endif

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int          cyc;
    bit          unit;
    logic [47:0] p;
    logic        co;
    bit          chk_pd;
    logic        pd;
    string       name;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  post_adder_acc dut (
    .CLK(clk), .RST(rst), .CEP(cep), .CEOPMODE(ceopmode), .CECARRYIN(cecarryin),
    .OPMODE(opmode), .M(m), .C(c), .DAB(dab), .PCIN(pcin), .CARRYIN(carryin),
    .P(p0), .PCOUT(pcout0), .CARRYOUT(co0), .CARRYOUTF(cof0)
`ifdef POST_ADDER_PATDET_EN
    , .PATTERNDETECT(pd0)
`endif
  );

  post_adder_acc #(.CARRYINSEL("CARRYIN")) dut_ci (
    .CLK(clk), .RST(rst), .CEP(cep), .CEOPMODE(ceopmode), .CECARRYIN(cecarryin),
    .OPMODE(opmode), .M(m), .C(c), .DAB(dab), .PCIN(pcin), .CARRYIN(carryin),
    .P(p1), .PCOUT(pcout1), .CARRYOUT(co1), .CARRYOUTF(cof1)
`ifdef POST_ADDER_PATDET_EN
    , .PATTERNDETECT(pd1)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Expectation that must hold after dly more rising edges.
  task automatic expect_at(input int dly, input bit unit, input logic [47:0] p,
                           input logic co, input string name,
                           input bit chk_pd = 1'b0, input logic pd = 1'b0);
    sb.push_back('{cyc + dly, unit, p, co, chk_pd, pd, name});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare every expectation due at this edge.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) check({e.name, "_late"}, 64'(cyc), 64'(e.cyc));
      else if (e.unit == 1'b0) begin
        check({e.name, "_p"},     64'(p0),     64'(e.p));
        check({e.name, "_pcout"}, 64'(pcout0), 64'(e.p));
        check({e.name, "_co"},    64'(co0),    64'(e.co));
        check({e.name, "_cof"},   64'(cof0),   64'(e.co));
`ifdef POST_ADDER_PATDET_EN
        if (e.chk_pd) check({e.name, "_pd"}, 64'(pd0), 64'(e.pd));
`endif
      end else begin
        check({e.name, "_p"},     64'(p1),     64'(e.p));
        check({e.name, "_pcout"}, 64'(pcout1), 64'(e.p));
        check({e.name, "_co"},    64'(co1),    64'(e.co));
        check({e.name, "_cof"},   64'(cof1),   64'(e.co));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    // Reset for two edges with arbitrary inputs and all enables high.
    rst = 1'b1; cep = 1'b1; ceopmode = 1'b1; cecarryin = 1'b1; carryin = 1'b0;
    opmode = 8'hFF; m = 36'hA_BCDE_F012; c = 48'h1111_2222_3333;
    dab = 48'h4444_5555_6666; pcin = 48'h7777_8888_9999;
    expect_at(1, 0, 48'd0, 1'b0, "rst1");
    expect_at(2, 0, 48'd0, 1'b0, "rst2");
    step(2);

    // P held at 0 with CEP low.
    rst = 1'b0; cep = 1'b0; opmode = 8'h03; dab = 48'd5;
    expect_at(1, 0, 48'd0, 1'b0, "hold1");
    expect_at(2, 0, 48'd0, 1'b0, "hold2");
    expect_at(3, 0, 48'd0, 1'b0, "hold3");
    step(3);

    // Accumulate M = 3; the registered OPMODE delays the first update.
    cep = 1'b1; opmode = 8'h09; m = 36'd3; dab = 48'd0;
    expect_at(1, 0, 48'd0,  1'b0, "acc0");
    expect_at(2, 0, 48'd3,  1'b0, "acc3");
    expect_at(3, 0, 48'd6,  1'b0, "acc6");
    expect_at(4, 0, 48'd9,  1'b0, "acc9");
    expect_at(5, 0, 48'd12, 1'b0, "acc12");
    step(5);

    // Reset mid-accumulation, then resume from 0.
    rst = 1'b1; c = 48'd3;
    expect_at(1, 0, 48'd0, 1'b0, "midrst", 1'b1, 1'b0);
    step(1);
    rst = 1'b0;
    expect_at(1, 0, 48'd0, 1'b0, "resume0", 1'b1, 1'b0);
    expect_at(2, 0, 48'd3, 1'b0, "resume3", 1'b1, 1'b1);
    expect_at(3, 0, 48'd6, 1'b0, "resume6", 1'b1, 1'b0);
    step(3);

    // Subtract C - (DAB + CIN); OPMODE5 carry arrives one stage after the mode.
    opmode = 8'hAF; c = 48'd100; dab = 48'd30;
    expect_at(1, 0, 48'd9,  1'b0, "sub_oldmode");
    expect_at(2, 0, 48'd70, 1'b0, "sub_nocin");
    expect_at(3, 0, 48'd69, 1'b0, "sub69");
    step(3);
    c = 48'd10;
    expect_at(1, 0, 48'hFFFF_FFFF_FFEB, 1'b1, "sub_borrow");
    step(1);

    // Load P = 2^48 - 1, then add 2 with Z = P to wrap.
    opmode = 8'h03; dab = 48'hFFFF_FFFF_FFFF;
    step(2);
    opmode = 8'h0B;
    expect_at(1, 0, 48'hFFFF_FFFF_FFFF, 1'b0, "ovf_load");
    step(1);
    dab = 48'd2;
    expect_at(1, 0, 48'd1, 1'b1, "ovf_wrap");
    expect_at(2, 0, 48'd3, 1'b0, "ovf_after");
    step(2);

    // Cascade: PCIN + DAB; second instance takes carry-in from CARRYIN.
    opmode = 8'h07; pcin = 48'h1234; dab = 48'd1; carryin = 1'b1;
    expect_at(1, 0, 48'd4,     1'b0, "casc_oldmode");
    expect_at(2, 0, 48'h1235,  1'b0, "casc");
    expect_at(2, 1, 48'h1236,  1'b0, "casc_carryin");
    expect_at(3, 0, 48'h1235,  1'b0, "casc_steady");
    expect_at(3, 1, 48'h1236,  1'b0, "casc_carryin_steady");
    step(3);

    // CEOPMODE low keeps the old mode despite OPMODE = 0.
    ceopmode = 1'b0; opmode = 8'h00;
    expect_at(1, 0, 48'h1235, 1'b0, "ceop_hold1");
    expect_at(2, 0, 48'h1235, 1'b0, "ceop_hold2");
    step(2);

    // CEP low holds P while operands change.
    ceopmode = 1'b1; cep = 1'b0; pcin = 48'd0;
    expect_at(1, 0, 48'h1235, 1'b0, "cep_hold1");
    expect_at(2, 0, 48'h1235, 1'b0, "cep_hold2");
    step(2);

    budget = 0;
    while (sb.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #1;
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
